bpsk_tx_scheduler: RTL and testbench

Frame-level sequencer that sits in front of the ROM-based BPSK modulator datapath. It pulls payload words from an upstream valid/ready source, optionally prepends a fixed preamble, and serialises each word into symbols. It drives the modulator's enable, sample index and symbol bit so that exactly one sine period (SAMPLE_NUMBER samples) is emitted per bit. It also reports frame status (busy, done, underrun).

---
 rtl/bpsk_pkg.sv | 21 ++
 rtl/bpsk_symbol_timer.sv | 38 +++
 rtl/bpsk_tx_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_bpsk_tx_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_pkg.sv
// Shared state encoding, default constants and width helper for the BPSK transmit path.
package bpsk_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StFetch    = 3'd1,
    StPreamble = 3'd2,
    StPayload  = 3'd3,
    StGap      = 3'd4
  } bpsk_state_e;

  localparam int unsigned SampleNumberDef    = 256;
  localparam int unsigned DataWidthDef       = 12;
  localparam logic [7:0]  PreamblePatternDef = 8'b1010_1011;

  // Never returns zero so a counter over a single value still gets one bit.
  function automatic int unsigned bpsk_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bpsk_symbol_timer.sv
// Sample counter for one sine period; wrap marks the last sample of a symbol.
module bpsk_symbol_timer import bpsk_pkg::*; #(
  parameter int unsigned SAMPLE_NUMBER = SampleNumberDef
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en,
  input  logic                                 clr,
  output logic [bpsk_width(SAMPLE_NUMBER)-1:0] idx,
  output logic                                 wrap
);

  localparam int unsigned IdxW = bpsk_width(SAMPLE_NUMBER);

  logic [IdxW-1:0] idx_q, idx_d;

  // Power-of-two period, so the natural overflow is the wrap to zero.
  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (en) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx  = idx_q;
  assign wrap = en && (idx_q == IdxW'(SAMPLE_NUMBER - 1));

endmodule

// File: rtl/bpsk_tx_scheduler.sv
// Frame sequencer driving the BPSK modulator: fetch, optional preamble, payload, gap.
// Optional preamble is built when BPSK_TX_PREAMBLE_EN is defined.
module bpsk_tx_scheduler import bpsk_pkg::*; #(
  parameter int unsigned SAMPLE_NUMBER   = SampleNumberDef,
  parameter int unsigned DATA_WIDTH      = DataWidthDef,
  parameter int unsigned FRAME_WORDS_MAX = 16,
  parameter int unsigned GAP_SYMBOLS     = 4
`ifdef BPSK_TX_PREAMBLE_EN
  ,
  parameter int unsigned             PREAMBLE_LEN     = 8,
  parameter logic [PREAMBLE_LEN-1:0] PREAMBLE_PATTERN = PreamblePatternDef
`endif
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [bpsk_width(FRAME_WORDS_MAX+1)-1:0] frame_len,
  input  logic [DATA_WIDTH-1:0]                  s_data,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  output logic                                   mod_en,
  output logic [bpsk_width(SAMPLE_NUMBER)-1:0]   mod_sample_idx,
  output logic                                   mod_bit,
  output logic                                   mod_sym_start,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   underrun
);

  localparam int unsigned IdxW = bpsk_width(SAMPLE_NUMBER);
  localparam int unsigned LenW = bpsk_width(FRAME_WORDS_MAX + 1);
  localparam int unsigned BitW = bpsk_width(DATA_WIDTH);
  localparam int unsigned GapW = bpsk_width(GAP_SYMBOLS);
`ifdef BPSK_TX_PREAMBLE_EN
  localparam int unsigned PreW = bpsk_width(PREAMBLE_LEN);
  localparam bpsk_state_e FirstTx = StPreamble;
`else
  localparam bpsk_state_e FirstTx = StPayload;
`endif

  bpsk_state_e           state_q, state_d;
  logic [LenW-1:0]       len_q, len_d, fetched_q, fetched_d, sent_q, sent_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d, completed_q, completed_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [GapW-1:0]       gap_q, gap_d;
`ifdef BPSK_TX_PREAMBLE_EN
  logic [PreW-1:0]       pre_q, pre_d;
`endif

  logic            timer_en, timer_clr, sym_wrap, take;
  logic [IdxW-1:0] sample_idx;

  assign timer_en  = (state_q == StPreamble) || (state_q == StPayload) || (state_q == StGap);
  assign timer_clr = !timer_en;

  bpsk_symbol_timer #(
    .SAMPLE_NUMBER(SAMPLE_NUMBER)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (timer_en),
    .clr  (timer_clr),
    .idx  (sample_idx),
    .wrap (sym_wrap)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    fetched_d    = fetched_q;
    sent_d       = sent_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    completed_d  = completed_q;
    bit_d        = bit_q;
    gap_d        = gap_q;
`ifdef BPSK_TX_PREAMBLE_EN
    pre_d        = pre_q;
`endif
    s_ready      = 1'b0;
    mod_en       = 1'b0;
    mod_bit      = 1'b0;
    done         = 1'b0;
    underrun     = 1'b0;
    take         = 1'b0;

    // Prefetch into the single holding register while a symbol stream is running.
    if ((state_q == StPreamble) || (state_q == StPayload)) begin
      s_ready = !hold_valid_q && (fetched_q < len_q);
      take    = s_valid && s_ready;
      if (take) begin
        hold_d       = s_data;
        hold_valid_d = 1'b1;
        fetched_d    = fetched_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start && (frame_len != '0) && (frame_len <= LenW'(FRAME_WORDS_MAX))) begin
          len_d        = frame_len;
          fetched_d    = '0;
          sent_d       = '0;
          hold_valid_d = 1'b0;
          completed_d  = 1'b0;
          state_d      = StFetch;
        end
      end
      StFetch: begin
        s_ready = 1'b1;
        if (s_valid) begin
          shift_d   = s_data;
          fetched_d = LenW'(1);
          sent_d    = LenW'(1);
          bit_d     = '0;
`ifdef BPSK_TX_PREAMBLE_EN
          pre_d     = '0;
`endif
          state_d   = FirstTx;
        end
      end
`ifdef BPSK_TX_PREAMBLE_EN
      StPreamble: begin
        mod_en  = 1'b1;
        mod_bit = PREAMBLE_PATTERN[pre_q];
        if (sym_wrap) begin
          if (pre_q == PreW'(PREAMBLE_LEN - 1)) begin
            pre_d   = '0;
            state_d = StPayload;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
      end
`endif
      StPayload: begin
        mod_en  = 1'b1;
        mod_bit = shift_q[0];
        if (sym_wrap) begin
          if (bit_q == BitW'(DATA_WIDTH - 1)) begin
            bit_d = '0;
            gap_d = '0;
            if (sent_q == len_q) begin
              completed_d = 1'b1;
              state_d     = StGap;
            end else if (hold_valid_q) begin
              shift_d      = hold_q;
              hold_valid_d = 1'b0;
              sent_d       = sent_q + 1'b1;
            end else begin
              underrun = 1'b1;
              state_d  = StGap;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
      StGap: begin
        if (sym_wrap) begin
          if (gap_q == GapW'(GAP_SYMBOLS - 1)) begin
            done    = completed_q;
            state_d = StIdle;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      len_q        <= '0;
      fetched_q    <= '0;
      sent_q       <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      completed_q  <= 1'b0;
      bit_q        <= '0;
      gap_q        <= '0;
`ifdef BPSK_TX_PREAMBLE_EN
      pre_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      fetched_q    <= fetched_d;
      sent_q       <= sent_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      completed_q  <= completed_d;
      bit_q        <= bit_d;
      gap_q        <= gap_d;
`ifdef BPSK_TX_PREAMBLE_EN
      pre_q        <= pre_d;
`endif
    end
  end

  // ROM address is parked at zero whenever the modulator is disabled.
  assign mod_sample_idx = mod_en ? sample_idx : '0;
  assign mod_sym_start  = mod_en && (sample_idx == '0);
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_bpsk_tx_scheduler.sv
// Self-checking bench: legality table, directed corner frames and randomized frames
// checked cycle by cycle against a frame timeline computed from symbol arithmetic.
module tb_bpsk_tx_scheduler;

  localparam int SN   = 8;
  localparam int DW   = 4;
  localparam int FMAX = 4;
  localparam int G    = 4;
`ifdef BPSK_TX_PREAMBLE_EN
  localparam int P = 8;
`else
  localparam int P = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    frame_len = '0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready, mod_en, mod_bit, mod_sym_start, busy, done, underrun;
  logic [2:0]    mod_sample_idx;

  always #5 clk = ~clk;

  bpsk_tx_scheduler #(
    .SAMPLE_NUMBER  (SN),
    .DATA_WIDTH     (DW),
    .FRAME_WORDS_MAX(FMAX),
    .GAP_SYMBOLS    (G)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .frame_len     (frame_len),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .mod_en        (mod_en),
    .mod_sample_idx(mod_sample_idx),
    .mod_bit       (mod_bit),
    .mod_sym_start (mod_sym_start),
    .busy          (busy),
    .done          (done),
    .underrun      (underrun)
  );

  int npass = 0;
  int ntotal = 0;

  logic [7:0]    pat = 8'b1010_1011;
  logic [DW-1:0] fw[FMAX];
  int            foff[FMAX];
  int            r[FMAX];
  int            flen, t0, e_end, gend, n_exp;
  bit            aborted;

  typedef struct {
    logic [2:0] len;
    logic       busy;
  } req_t;
  req_t reqs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] pack(input logic b, input logic en, input logic [2:0] idx,
                                       input logic bt, input logic sy, input logic un,
                                       input logic dn, input logic rd);
    return {22'd0, b, en, idx, bt, sy, un, dn, rd};
  endfunction

  function automatic logic [31:0] all_outs();
    return {21'd0, s_ready, mod_en, mod_sample_idx, mod_bit, mod_sym_start, busy, done, underrun};
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0;
    @(posedge clk); #1;
    chk("reset_outputs", all_outs(), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Cycle 0 is the first FETCH cycle; word k ends its last bit at t0+(P+(k+1)*DW)*SN-1.
  task automatic plan_frame();
    int m, b;
    for (int k = 0; k < FMAX; k++) r[k] = 1 << 30;
    r[0] = (foff[0] < 0) ? 0 : foff[0];
    t0 = r[0] + 1;
    aborted = 1'b0;
    m = flen - 1;
    for (int k = 1; k < flen; k++) begin
      b = t0 + (P + k * DW) * SN - 1;
      r[k] = b + foff[k];
      if (r[k] < 0) r[k] = 0;
      if (r[k] >= b) begin
        aborted = 1'b1;
        m = k - 1;
        break;
      end
    end
    e_end = t0 + (P + (m + 1) * DW) * SN - 1;
    gend  = e_end + G * SN;
    n_exp = m + 1 + ((aborted && r[m + 1] == e_end) ? 1 : 0);
  endtask

  task automatic check_cycle(input int c);
    bit en, rk;
    int s;
    logic [2:0] eidx;
    logic ebit;
    en = (c >= t0) && (c <= e_end);
    eidx = '0;
    ebit = 1'b0;
    if (en) begin
      s = (c - t0) / SN;
      eidx = 3'((c - t0) % SN);
      if (s < P) ebit = pat[s];
      else ebit = fw[(s - P) / DW][(s - P) % DW];
    end
    rk = (c < t0) || (c > e_end);
    chk($sformatf("cycle%0d", c),
        pack(busy, mod_en, en ? mod_sample_idx : 3'd0, en ? mod_bit : 1'b0, mod_sym_start,
             underrun, done, rk ? s_ready : 1'b0),
        pack(c <= gend, en, eidx, ebit, en && (eidx == 3'd0), aborted && (c == e_end),
             !aborted && (c == gend), c < t0));
  endtask

  task automatic run_frame(input bit inject);
    int j, acc;
    plan_frame();
    @(posedge clk); #1;
    start = 1'b1; frame_len = 3'(flen); s_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    j = 0;
    acc = 0;
    for (int c = 0; c <= gend + 2; c++) begin
      if (j < flen && c >= r[j] && c <= gend) begin
        s_valid = 1'b1; s_data = fw[j];
      end else begin
        s_valid = 1'b0; s_data = DW'($urandom);
      end
      start = inject && (c > 0) && (c <= gend) && ($urandom_range(0, 15) == 0);
      frame_len = 3'($urandom);
      #1;
      check_cycle(c);
      if (s_valid && s_ready) begin
        acc++;
        j++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    s_valid = 1'b0;
    chk("words_accepted", acc, n_exp);
  endtask

  initial begin
    do_reset();

    reqs[0] = '{len: 3'd0, busy: 1'b0};
    reqs[1] = '{len: 3'd1, busy: 1'b1};
    reqs[2] = '{len: 3'd4, busy: 1'b1};
    reqs[3] = '{len: 3'd5, busy: 1'b0};
    reqs[4] = '{len: 3'd7, busy: 1'b0};
    reqs[5] = '{len: 3'd3, busy: 1'b1};
    for (int i = 0; i < 6; i++) begin
      do_reset();
      start = 1'b1; frame_len = reqs[i].len;
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      chk("req_accept", {27'd0, busy, s_ready, mod_en, done, underrun},
          {27'd0, reqs[i].busy, reqs[i].busy, 3'b000});
      @(posedge clk); #1;
      chk("req_hold", {31'd0, busy}, {31'd0, reqs[i].busy});
    end
    do_reset();

    // Single word 0110, valid from the first cycle.
    flen = 1; fw[0] = 4'b0110; foff[0] = 0;
    run_frame(1'b0);
    // Three always-valid words with stray start pulses while busy.
    flen = 3; fw[0] = 4'h5; fw[1] = 4'hA; fw[2] = 4'hF;
    foff[0] = 0; foff[1] = -1000; foff[2] = -1000;
    run_frame(1'b1);
    // Second word arrives one cycle after the first word's final wrap.
    flen = 2; fw[0] = 4'h3; fw[1] = 4'hC; foff[0] = 2; foff[1] = 1;
    run_frame(1'b0);
    // Second word arrives exactly on the wrap cycle: still too late to continue.
    flen = 2; fw[0] = 4'h9; fw[1] = 4'h6; foff[0] = 0; foff[1] = 0;
    run_frame(1'b0);
    // One cycle earlier it is seamless.
    flen = 2; foff[1] = -1;
    run_frame(1'b0);

    // Reset in the middle of payload bit 2.
    @(posedge clk); #1;
    start = 1'b1; frame_len = 3'd2; s_valid = 1'b1; s_data = 4'h9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat ((P + 2) * SN + 4) @(posedge clk);
    #1;
    chk("pre_reset_bit2", {27'd0, mod_en, mod_sample_idx, mod_bit}, {27'd0, 1'b1, 3'd3, 1'b0});
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; s_valid = 1'b0;
    #1;
    chk("mid_reset_outputs", all_outs(), 32'd0);
    @(posedge clk); #1;
    chk("mid_reset_idle", all_outs(), 32'd0);
    flen = 2; fw[0] = 4'hB; fw[1] = 4'h4; foff[0] = 1; foff[1] = -20;
    run_frame(1'b0);

    for (int n = 0; n < 30; n++) begin
      flen = $urandom_range(1, FMAX);
      for (int k = 0; k < FMAX; k++) begin
        fw[k] = DW'($urandom);
        foff[k] = $urandom_range(0, 40) - 36;
      end
      foff[0] = $urandom_range(0, 5);
      run_frame(1'b1);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
